// File: rtl/sap_mem_pkg.sv
// rtl/sap_mem_pkg.sv - shared types and sizes for the SAP program/data store
package sap_mem_pkg;
    localparam int MEM_DEPTH = 16;
    localparam int MEM_AW    = 4;
    localparam int MEM_DW    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;
endpackage

// File: rtl/ram_16x8_loader.sv
// rtl/ram_16x8_loader.sv - 16x8 store with streaming loader and run-mode write port
// Optional LOAD_CHECKSUM_EN adds the ld_sum port and its accumulator.
module ram_16x8_loader
    import sap_mem_pkg::*;
#(
    parameter int WIDTH    = MEM_DW,
    parameter int DEPTH    = MEM_DEPTH,
    parameter int LOAD_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_mode,
    input  logic                   ld_valid,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   ld_ready,
    output logic                   ld_done,
    input  logic                   wr_en,
    input  logic [MEM_AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
`ifdef LOAD_CHECKSUM_EN
    output logic [WIDTH-1:0]       ld_sum,
`endif
    output logic [WIDTH*DEPTH-1:0] mem_flat
);
    localparam logic [MEM_AW-1:0] LAST = MEM_AW'(LOAD_LEN - 1);

    ld_state_t         state, next_state;
    logic [MEM_AW-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              ld_we, run_we, ptr_clr, entry;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A handshake only counts while prog_mode is still held; an abort discards it.
    always_comb begin
        next_state = state;
        ld_we      = 1'b0;
        run_we     = 1'b0;
        ptr_clr    = 1'b0;
        entry      = 1'b0;
        case (state)
            IDLE: begin
                if (prog_mode) begin
                    next_state = LOAD;
                    ptr_clr    = 1'b1;
                    entry      = 1'b1;
                end else begin
                    run_we = wr_en;
                end
            end
            LOAD: begin
                if (!prog_mode) begin
                    next_state = IDLE;
                    ptr_clr    = 1'b1;
                end else if (ld_valid) begin
                    ld_we = 1'b1;
                    if (ptr == LAST) next_state = DONE;
                end
            end
            DONE: begin
                if (!prog_mode) begin
                    next_state = IDLE;
                    ptr_clr    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ld_ready = (state == LOAD);
    assign ld_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ld_we)       mem[ptr]     <= ld_data;
            else if (run_we) mem[wr_addr] <= wr_data;
            // ptr parks on the last slot once the session completes
            if (ptr_clr)                  ptr <= '0;
            else if (ld_we && ptr != LAST) ptr <= ptr + 1'b1;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || entry) ld_sum <= '0;
        else if (ld_we)   ld_sum <= ld_sum + ld_data;
    end
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[WIDTH*g +: WIDTH] = mem[g];
    end
endmodule
